axi4_stream_target_type_2: RTL and testbench
============================================

Name: axi4_stream_target_type_2

Overview:
Multi-channel, self-checking AXI4-Stream sink for testbenches. It drains interleaved streams that share one TDEST, tells them apart by TID, and checks each channel's tdata sequence, tlast position and stream structure independently. Backpressure comes from a selectable tready generator (always, periodic, or pseudo-random). It replaces the single-stream type 1 sink wherever a router or arbiter under test merges several initiators onto one target port.

Parameters:
- TDataWidth, 32, tdata width in bits (8..64)
- TIdWidth, 4, tid width
- TDestWidth, 4, tdest width
- NumChannels, 4, independent streams tracked (1..2^TIdWidth)
- TIdBase, 0, TID of channel 0; channel c = tid - TIdBase
- TDest, 0, only TDEST accepted as valid
- TargetMode, "LOOP", "SINGLE" or "LOOP"
- ReadyMode, "ALWAYS", "ALWAYS", "PERIODIC" or "RANDOM"
- CyclesActive, 4, PERIODIC: tready-high cycles per period (>=1)
- CyclesPause, 2, PERIODIC: tready-low cycles per period
- LfsrSeed, 16'hACE1, RANDOM: 16-bit LFSR seed (nonzero)
- ReadyThreshold, 8, RANDOM: tready=1 when lfsr[3:0] < threshold (0..16)
- TransfersPerPacket, 4, transfers per packet (0 treated as 1)
- PacketsPerFrame, 2, packets per frame (0 treated as 1)
- FramesPerStream, 2, frames per stream (0 treated as 1)
- TlastTrigger, "PACKET", "NONE", "TRANSFER", "PACKET", "FRAME" or "STREAM"
- TDataInitialValue, 32'hABCD0A00, channel 0 start value (truncated to TDataWidth)
- TDataIncrement, 32'h00010001, per-transfer increment (truncated)

Ports:
- clk_s_axis_i  in  1  clock
- rst_s_axis_ni  in  1  asynchronous active-low reset
- s_axis_tvalid_i  in  1  transfer valid
- s_axis_tready_o  out  1  transfer ready
- s_axis_tdata_i  in  TDataWidth  data
- s_axis_tlast_i  in  1  last flag
- s_axis_tid_i  in  TIdWidth  stream id
- s_axis_tdest_i  in  TDestWidth  destination
- chan_done_o  out  NumChannels  per-channel stream complete (SINGLE mode)
- all_done_o  out  1  all channels done
- err_flags_o  out  5  sticky: [0] tdata, [1] tlast, [2] tdest, [3] tid out of range, [4] transfer to done channel
- err_count_o  out  16  saturating count of erroneous transfers
- xfer_count_o  out  32  accepted-transfer count, wraps

Behaviour:
- Reset (async assert, sync release): tready=0, chan_done=0, all_done=0, err_flags=0, err_count=0, xfer_count=0, LFSR=LfsrSeed. Per channel c: counters at initial value, expected data = TDataInitialValue + c (mod 2^TDataWidth).
- Handshake: a transfer is accepted on a rising edge with tvalid & tready. tready is registered and never depends on tvalid. xfer_count increments on every accepted transfer.
- Ready generator:
  - ALWAYS: tready=1 from the first edge after reset release.
  - PERIODIC: CyclesActive high, then CyclesPause low, repeating. Starts with the active phase. CyclesPause=0 gives constant 1.
  - RANDOM: LFSR with taps 16,14,13,11 advances every cycle. tready <= (lfsr[3:0] < ReadyThreshold).
  - All modes: tready is forced 0 while all_done=1.
- Classification per accepted transfer, in priority order:
  1. tdest != TDest: flag[2]. No channel state changes.
  2. c outside 0..NumChannels-1: flag[3]. No channel state changes.
  3. chan_done[c]: flag[4]. No channel state changes.
  4. Otherwise compare against channel c's expected values. tdata mismatch sets flag[0]; tlast mismatch sets flag[1]. Expected data advances by TDataIncrement, and the counters advance transfer -> packet -> frame, reloading on wrap. Channel state advances even when the transfer mismatches.
- Expected tlast:
  - NONE: 0.
  - TRANSFER: 1.
  - PACKET: last transfer of the packet.
  - FRAME: last transfer of the last packet.
  - STREAM: last transfer of the last frame.
- err_count increments by 1 per transfer with any flag condition and saturates at 16'hFFFF.
- End of stream, on the last transfer of the last frame for channel c:
  - SINGLE: chan_done[c] <= 1 on that edge.
  - LOOP: channel c reloads counters and expected data to its reset values and continues.
  - all_done = &chan_done, registered: it rises one cycle after the final channel completes, and tready drops in that same cycle.
- Channels interleave at transfer granularity. There is no packet-atomicity requirement.
- Reset asserted mid-stream returns every register to its reset value immediately, with no partial-packet memory.

Optional Feature:
- Macro: AXI4_STREAM_TARGET_TYPE_2_ERROR_CAPTURE_EN
- Defined: adds outputs first_err_valid_o (1), first_err_data_o (TDataWidth), first_err_expected_o (TDataWidth), first_err_tid_o (TIdWidth) and first_err_index_o (32, the xfer_count value of the failing transfer). They capture only the first erroneous transfer after reset and hold until reset. Expected is 0 for flag[2], [3] and [4] errors.
- Not defined: none of these ports or registers exist. All other behaviour is identical.

Test Plan:
- Default params; one initiator on TID 0 sends 16 transfers (tdata 0xABCD0A00, +0x00010001 each; tlast every 4th) -> err_flags=0, xfer_count=16; in SINGLE mode chan_done=4'b0001.
- SINGLE mode, 4 channels round-robin interleaved, 16 transfers each -> all_done rises 1 cycle after the 64th acceptance, tready then stays 0, err_count=0.
- Channel 2 transfer 5 has tdata corrupted to 0 -> flag[0] set, err_count=1, transfer 6 on channel 2 checks clean (expected value kept advancing).
- tdest=1 on one transfer, then tid=9 with NumChannels=4 -> flags [2] and [3] set, err_count=2, no channel counter advances.
- PERIODIC with CyclesActive=4, CyclesPause=2, tvalid held high -> tready pattern 111100 repeating; xfer_count=20 after 30 cycles.
- Reset asserted mid-packet on channel 1, then a stream restarted from its first value -> all outputs reset asynchronously; the restarted stream checks clean.

Source files
------------

// File: rtl/axi4_stream_target_type_2.sv
// Multi-channel self-checking AXI4-Stream sink: demuxes interleaved streams by TID and checks each independently.
// Optional first-error capture ports: define AXI4_STREAM_TARGET_TYPE_2_ERROR_CAPTURE_EN.
module axi4_stream_target_type_2 #(
   parameter int          TDataWidth         = 32,
   parameter int          TIdWidth           = 4,
   parameter int          TDestWidth         = 4,
   parameter int          NumChannels        = 4,
   parameter int          TIdBase            = 0,
   parameter int          TDest              = 0,
   parameter string       TargetMode         = "LOOP",
   parameter string       ReadyMode          = "ALWAYS",
   parameter int          CyclesActive       = 4,
   parameter int          CyclesPause        = 2,
   parameter logic [15:0] LfsrSeed           = 16'hACE1,
   parameter int          ReadyThreshold     = 8,
   parameter int          TransfersPerPacket = 4,
   parameter int          PacketsPerFrame    = 2,
   parameter int          FramesPerStream    = 2,
   parameter string       TlastTrigger       = "PACKET",
   parameter logic [63:0] TDataInitialValue  = 64'hABCD0A00,
   parameter logic [63:0] TDataIncrement     = 64'h00010001
) (
   input  logic                   clk_s_axis_i,
   input  logic                   rst_s_axis_ni,
   input  logic                   s_axis_tvalid_i,
   output logic                   s_axis_tready_o,
   input  logic [TDataWidth-1:0]  s_axis_tdata_i,
   input  logic                   s_axis_tlast_i,
   input  logic [TIdWidth-1:0]    s_axis_tid_i,
   input  logic [TDestWidth-1:0]  s_axis_tdest_i,
   output logic [NumChannels-1:0] chan_done_o,
   output logic                   all_done_o,
   output logic [4:0]             err_flags_o,
   output logic [15:0]            err_count_o,
   output logic [31:0]            xfer_count_o
`ifdef AXI4_STREAM_TARGET_TYPE_2_ERROR_CAPTURE_EN
   ,
   output logic                   first_err_valid_o,
   output logic [TDataWidth-1:0]  first_err_data_o,
   output logic [TDataWidth-1:0]  first_err_expected_o,
   output logic [TIdWidth-1:0]    first_err_tid_o,
   output logic [31:0]            first_err_index_o
`endif
);

   localparam int Tpp    = (TransfersPerPacket < 1) ? 1 : TransfersPerPacket;
   localparam int Ppf    = (PacketsPerFrame < 1) ? 1 : PacketsPerFrame;
   localparam int Fps    = (FramesPerStream < 1) ? 1 : FramesPerStream;
   localparam int Period = CyclesActive + CyclesPause;
   localparam bit IsSingle = (TargetMode == "SINGLE");
   localparam int RdySel  = (ReadyMode == "PERIODIC") ? 1 : (ReadyMode == "RANDOM") ? 2 : 0;
   localparam int LastSel = (TlastTrigger == "NONE") ? 0 :
                            (TlastTrigger == "TRANSFER") ? 1 :
                            (TlastTrigger == "PACKET") ? 2 :
                            (TlastTrigger == "FRAME") ? 3 : 4;
   localparam logic [TDataWidth-1:0] InitData = TDataInitialValue[TDataWidth-1:0];
   localparam logic [TDataWidth-1:0] IncData  = TDataIncrement[TDataWidth-1:0];

   // Handshake: a transfer moves on a rising edge where tvalid and tready are both
   // high; tready is a register driven only by the generator and all_done, never tvalid.
   logic                   tready_q;
   logic                   all_done_q;
   logic [NumChannels-1:0] chan_done_q;
   logic [4:0]             err_flags_q;
   logic [15:0]            err_count_q;
   logic [31:0]            xfer_count_q;
   logic [15:0]            lfsr_q;
   logic [31:0]            phase_q;
   logic                   gen_ready;

   logic [TDataWidth-1:0]  exp_data_q [NumChannels];
   logic [31:0]            xfer_cnt_q [NumChannels];
   logic [31:0]            pkt_cnt_q  [NumChannels];
   logic [31:0]            frm_cnt_q  [NumChannels];

   logic                   acc;
   logic [31:0]            tid_ext;
   logic [31:0]            ch_off;
   logic                   in_range;
   logic [TDataWidth-1:0]  sel_exp;
   logic [31:0]            sel_xfer, sel_pkt, sel_frm;
   logic                   sel_done;
   logic                   last_xfer, last_pkt, last_frm, end_of_stream;
   logic                   exp_last;
   logic                   tdest_err, tid_err, done_err, data_err, last_err;
   logic                   chk_ok, any_err;

   assign acc = s_axis_tvalid_i & tready_q;

   always_comb begin
      gen_ready = 1'b1;
      case (RdySel)
         1:       gen_ready = (phase_q < 32'(CyclesActive));
         2:       gen_ready = ({1'b0, lfsr_q[3:0]} < 5'(ReadyThreshold));
         default: gen_ready = 1'b1;
      endcase
   end

   always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
      if (!rst_s_axis_ni) begin
         tready_q   <= 1'b0;
         all_done_q <= 1'b0;
         lfsr_q     <= LfsrSeed;
         phase_q    <= '0;
      end else begin
         // all_done and the tready drop both follow &chan_done on the same edge
         all_done_q <= &chan_done_q;
         tready_q   <= gen_ready & ~(&chan_done_q);
         lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         phase_q    <= (phase_q >= 32'(Period - 1)) ? 32'd0 : phase_q + 32'd1;
      end
   end

   // Channel lookup and per-transfer classification
   always_comb begin
      tid_ext  = 32'(s_axis_tid_i);
      ch_off   = tid_ext - 32'(TIdBase);
      in_range = (tid_ext >= 32'(TIdBase)) && (ch_off < 32'(NumChannels));
      sel_exp  = '0;
      sel_xfer = '0;
      sel_pkt  = '0;
      sel_frm  = '0;
      sel_done = 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
         if (ch_off == 32'(c)) begin
            sel_exp  = exp_data_q[c];
            sel_xfer = xfer_cnt_q[c];
            sel_pkt  = pkt_cnt_q[c];
            sel_frm  = frm_cnt_q[c];
            sel_done = chan_done_q[c];
         end
      end
      last_xfer     = (sel_xfer == 32'(Tpp - 1));
      last_pkt      = (sel_pkt == 32'(Ppf - 1));
      last_frm      = (sel_frm == 32'(Fps - 1));
      end_of_stream = last_xfer & last_pkt & last_frm;
      case (LastSel)
         0:       exp_last = 1'b0;
         1:       exp_last = 1'b1;
         2:       exp_last = last_xfer;
         3:       exp_last = last_xfer & last_pkt;
         default: exp_last = end_of_stream;
      endcase
      tdest_err = (s_axis_tdest_i != TDestWidth'(TDest));
      tid_err   = ~tdest_err & ~in_range;
      done_err  = ~tdest_err & in_range & sel_done;
      chk_ok    = ~tdest_err & in_range & ~sel_done;
      data_err  = chk_ok & (s_axis_tdata_i != sel_exp);
      last_err  = chk_ok & (s_axis_tlast_i != exp_last);
      any_err   = tdest_err | tid_err | done_err | data_err | last_err;
   end

   // Channel state advances on every checked transfer, mismatched or not
   always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
      if (!rst_s_axis_ni) begin
         chan_done_q <= '0;
         for (int c = 0; c < NumChannels; c++) begin
            exp_data_q[c] <= InitData + TDataWidth'(c);
            xfer_cnt_q[c] <= '0;
            pkt_cnt_q[c]  <= '0;
            frm_cnt_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NumChannels; c++) begin
            if (acc && chk_ok && (ch_off == 32'(c))) begin
               xfer_cnt_q[c] <= last_xfer ? 32'd0 : sel_xfer + 32'd1;
               if (last_xfer)
                  pkt_cnt_q[c] <= last_pkt ? 32'd0 : sel_pkt + 32'd1;
               if (last_xfer && last_pkt)
                  frm_cnt_q[c] <= last_frm ? 32'd0 : sel_frm + 32'd1;
               if (end_of_stream && !IsSingle)
                  exp_data_q[c] <= InitData + TDataWidth'(c);
               else
                  exp_data_q[c] <= sel_exp + IncData;
               if (end_of_stream && IsSingle)
                  chan_done_q[c] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
      if (!rst_s_axis_ni) begin
         err_flags_q  <= '0;
         err_count_q  <= '0;
         xfer_count_q <= '0;
      end else if (acc) begin
         xfer_count_q <= xfer_count_q + 32'd1;
         err_flags_q  <= err_flags_q | {done_err, tid_err, tdest_err, last_err, data_err};
         if (any_err && (err_count_q != 16'hFFFF))
            err_count_q <= err_count_q + 16'd1;
      end
   end

`ifdef AXI4_STREAM_TARGET_TYPE_2_ERROR_CAPTURE_EN
   logic                  cap_valid_q;
   logic [TDataWidth-1:0] cap_data_q, cap_exp_q;
   logic [TIdWidth-1:0]   cap_tid_q;
   logic [31:0]           cap_index_q;

   always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
      if (!rst_s_axis_ni) begin
         cap_valid_q <= 1'b0;
         cap_data_q  <= '0;
         cap_exp_q   <= '0;
         cap_tid_q   <= '0;
         cap_index_q <= '0;
      end else if (acc && any_err && !cap_valid_q) begin
         cap_valid_q <= 1'b1;
         cap_data_q  <= s_axis_tdata_i;
         // routing-class errors have no meaningful expected data
         cap_exp_q   <= (data_err | last_err) ? sel_exp : '0;
         cap_tid_q   <= s_axis_tid_i;
         cap_index_q <= xfer_count_q;
      end
   end

   assign first_err_valid_o    = cap_valid_q;
   assign first_err_data_o     = cap_data_q;
   assign first_err_expected_o = cap_exp_q;
   assign first_err_tid_o      = cap_tid_q;
   assign first_err_index_o    = cap_index_q;
`endif

   assign s_axis_tready_o = tready_q;
   assign chan_done_o     = chan_done_q;
   assign all_done_o      = all_done_q;
   assign err_flags_o     = err_flags_q;
   assign err_count_o     = err_count_q;
   assign xfer_count_o    = xfer_count_q;

endmodule

// File: tb/tb_axi4_stream_target_type_2.sv
// Bench for axi4_stream_target_type_2: SINGLE/ALWAYS instance for checking paths, PERIODIC/LOOP instance for backpressure.
`timescale 1ns/1ps
module tb_axi4_stream_target_type_2;

   localparam int SW = 58;

   // clock / reset
   logic clk_s_axis_i = 1'b0;
   always #5 clk_s_axis_i = ~clk_s_axis_i;

   logic        rst_n, rst_p_n;
   logic        tvalid, tlast;
   logic [31:0] tdata;
   logic [3:0]  tid, tdest;
   logic        tready, all_done;
   logic [3:0]  chan_done;
   logic [4:0]  err_flags;
   logic [15:0] err_count;
   logic [31:0] xfer_count;

   logic        tvalid_p, tready_p, all_done_p;
   logic [3:0]  chan_done_p;
   logic [4:0]  err_flags_p;
   logic [15:0] err_count_p;
   logic [31:0] xfer_count_p;

   axi4_stream_target_type_2 #(.TargetMode("SINGLE"), .ReadyMode("ALWAYS")) dut (
      .clk_s_axis_i(clk_s_axis_i), .rst_s_axis_ni(rst_n),
      .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready), .s_axis_tdata_i(tdata),
      .s_axis_tlast_i(tlast), .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
      .chan_done_o(chan_done), .all_done_o(all_done), .err_flags_o(err_flags),
      .err_count_o(err_count), .xfer_count_o(xfer_count));

   axi4_stream_target_type_2 #(.TargetMode("LOOP"), .ReadyMode("PERIODIC"),
                               .CyclesActive(4), .CyclesPause(2)) dut_p (
      .clk_s_axis_i(clk_s_axis_i), .rst_s_axis_ni(rst_p_n),
      .s_axis_tvalid_i(tvalid_p), .s_axis_tready_o(tready_p), .s_axis_tdata_i(32'h0),
      .s_axis_tlast_i(1'b0), .s_axis_tid_i(4'h0), .s_axis_tdest_i(4'h0),
      .chan_done_o(chan_done_p), .all_done_o(all_done_p), .err_flags_o(err_flags_p),
      .err_count_o(err_count_p), .xfer_count_o(xfer_count_p));

   // scoreboard state
   logic [SW-1:0] exp_q[$];
   int            n_chk = 0;
   int            n_pass = 0;
   logic [4:0]    exp_flags;
   logic [15:0]   exp_errs;
   logic [31:0]   exp_xfer;
   logic [3:0]    exp_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] gold(input int c, input int k);
      logic [31:0] base;
      base = 32'hABCD0A00 + 32'(c);
      return base + 32'(k) * 32'h00010001;
   endfunction

   function automatic logic [SW-1:0] status_now();
      return {all_done, chan_done, err_flags, err_count, xfer_count};
   endfunction

   // driver tasks
   task automatic send(input int tid_v, input int dest_v, input logic [31:0] d, input logic l,
                       input logic [4:0] eb, input logic [3:0] done_set);
      int waits = 0;
      @(negedge clk_s_axis_i);
      tvalid = 1'b1; tid = 4'(tid_v); tdest = 4'(dest_v); tdata = d; tlast = l;
      while (!tready && waits < 50) begin
         @(negedge clk_s_axis_i);
         waits++;
      end
      if (!tready) begin
         check("send_timeout", 64'(tready), 64'd1);
         tvalid = 1'b0;
         return;
      end
      @(posedge clk_s_axis_i);
      exp_flags = exp_flags | eb;
      if (eb != 5'd0) exp_errs = exp_errs + 16'd1;
      exp_xfer = exp_xfer + 32'd1;
      exp_done = exp_done | done_set;
      exp_q.push_back({1'b0, exp_done, exp_flags, exp_errs, exp_xfer});
   endtask

   task automatic send_good(input int c, input int k);
      send(c, 0, gold(c, k), ((k % 4) == 3), 5'd0, (k == 15) ? 4'(1 << c) : 4'd0);
   endtask

   task automatic idle();
      @(negedge clk_s_axis_i);
      tvalid = 1'b0;
   endtask

   task automatic clear_model();
      exp_flags = '0; exp_errs = '0; exp_xfer = '0; exp_done = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_s_axis_i);
      rst_n = 1'b0; tvalid = 1'b0;
      repeat (2) @(negedge clk_s_axis_i);
      clear_model();
      rst_n = 1'b1;
      @(negedge clk_s_axis_i);
   endtask

   // monitor: every accepted transfer pops one expected status
   always @(posedge clk_s_axis_i) begin
      if (tvalid && tready) begin
         #1;
         if (exp_q.size() == 0) check("unexpected_xfer", 64'(status_now()), 64'd0);
         else check("status", 64'(status_now()), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tvalid = 1'b0; tlast = 1'b0; tdata = '0; tid = '0; tdest = '0; tvalid_p = 1'b0;
      rst_n = 1'b0; rst_p_n = 1'b0;
      clear_model();
      repeat (3) @(negedge clk_s_axis_i);
      check("reset_tready", 64'(tready), 64'd0);
      check("reset_status", 64'(status_now()), 64'd0);
      rst_n = 1'b1;
      @(negedge clk_s_axis_i);
      check("tready_after_release", 64'(tready), 64'd1);

      // single clean stream on channel 0, then one transfer to the finished channel
      for (int k = 0; k < 16; k++) send_good(0, k);
      idle();
      check("ch0_done", 64'(chan_done), 64'h1);
      send(0, 0, gold(0, 0), 1'b0, 5'b10000, 4'd0);
      idle();

      // wrong tdest, out-of-range tid, then channel 0 still expects its first value
      do_reset();
      send(0, 1, gold(0, 0), 1'b0, 5'b00100, 4'd0);
      send(9, 0, gold(0, 0), 1'b0, 5'b01000, 4'd0);
      send_good(0, 0);
      idle();
      check("route_err_count", 64'(err_count), 64'd2);

      // channel 2 transfer 5 corrupted; transfer 6 checks clean
      do_reset();
      for (int k = 0; k < 7; k++) begin
         if (k == 5) send(2, 0, 32'h0, 1'b0, 5'b00001, 4'd0);
         else send_good(2, k);
      end
      idle();
      check("corrupt_err_count", 64'(err_count), 64'd1);

      // asynchronous reset mid-packet on channel 1
      do_reset();
      send_good(1, 0);
      send_good(1, 1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_status", 64'(status_now()), 64'd0);
      check("async_reset_tready", 64'(tready), 64'd0);
      @(negedge clk_s_axis_i);
      clear_model();
      rst_n = 1'b1;
      @(negedge clk_s_axis_i);

      // four channels round-robin to completion
      for (int k = 0; k < 16; k++)
         for (int c = 0; c < 4; c++) send_good(c, k);
      idle();
      check("all_done_not_yet", 64'(all_done), 64'd0);
      @(negedge clk_s_axis_i);
      check("all_done_rise", 64'(all_done), 64'd1);
      check("tready_drop", 64'(tready), 64'd0);
      repeat (5) @(negedge clk_s_axis_i);
      check("tready_held_low", 64'(tready), 64'd0);
      check("rr_err_count", 64'(err_count), 64'd0);
      check("rr_xfer_count", 64'(xfer_count), 64'd64);

      // periodic backpressure with tvalid held high
      @(negedge clk_s_axis_i);
      tvalid_p = 1'b1;
      rst_p_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_s_axis_i);
         #1;
         check("periodic_tready", 64'(tready_p), ((i % 6) < 4) ? 64'd1 : 64'd0);
      end
      check("periodic_xfer_count", 64'(xfer_count_p), 64'd20);
      tvalid_p = 1'b0;

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
